// File: rtl/gray_seq_tracker.sv
// Sequence tracker: walks a loadable STEPS-long symbol table one step per match,
// exposing a Gray or binary encoded step plus advance/mismatch/wrap pulses.
module gray_seq_tracker #(
    parameter int STEPS    = 32,
    parameter int IN_W     = 2,
    parameter int ENC      = 0,
    parameter int MISMATCH = 0,
    parameter int WRAP_W   = 8,
    localparam int SW      = $clog2(STEPS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [IN_W-1:0]   in,
    input  logic              load_en,
    input  logic [SW-1:0]     load_addr,
    input  logic [IN_W-1:0]   load_data,
    output logic [SW-1:0]     state,
    output logic [SW-1:0]     step,
    output logic              advance,
    output logic              mismatch,
    output logic              wrap,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              out_signal
);

    localparam int XW = (SW < 3) ? SW : 3;
    localparam logic [SW-1:0] LAST = SW'(STEPS - 1);

    logic [IN_W-1:0] tbl [STEPS];
    logic            hit;

    assign hit = (in == tbl[step]);

    always_ff @(posedge clk) begin
        if (reset) begin
            step       <= '0;
            advance    <= 1'b0;
            mismatch   <= 1'b0;
            wrap       <= 1'b0;
            wrap_count <= '0;
            for (int i = 0; i < STEPS; i++)
                tbl[i] <= IN_W'(i);
        end else begin
            advance  <= 1'b0;
            mismatch <= 1'b0;
            wrap     <= 1'b0;
            // compare above reads the pre-write entry
            if (load_en)
                tbl[load_addr] <= load_data;
            if (en) begin
                if (hit) begin
                    advance <= 1'b1;
                    if (step == LAST) begin
                        step <= '0;
                        wrap <= 1'b1;
                        if (wrap_count != '1)
                            wrap_count <= wrap_count + 1'b1;
                    end else begin
                        step <= step + 1'b1;
                    end
                end else begin
                    mismatch <= 1'b1;
                    if (MISMATCH != 0)
                        step <= '0;
                end
            end
        end
    end

    assign state      = (ENC == 0) ? (step ^ (step >> 1)) : step;
    assign out_signal = ^state[XW-1:0];

endmodule

// File: tb/tb_gray_seq_tracker.sv
// Directed bench for gray_seq_tracker: four parameter variants share one
// stimulus stream; each check compares against hand-derived values.
module tb_gray_seq_tracker;

    logic       clk = 1'b0;
    logic       reset, en, load_en;
    logic [1:0] in_s, load_data;
    logic [4:0] load_addr;

    logic [4:0] st [4];
    logic [4:0] sp [4];
    logic       adv [4];
    logic       mm [4];
    logic       wr [4];
    logic       os [4];
    logic [7:0] wc0, wc1, wc3;
    logic [1:0] wc2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gray_seq_tracker #(.MISMATCH(0)) d0 (
        .clk(clk), .reset(reset), .en(en), .in(in_s),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .state(st[0]), .step(sp[0]), .advance(adv[0]), .mismatch(mm[0]),
        .wrap(wr[0]), .wrap_count(wc0), .out_signal(os[0]));

    gray_seq_tracker #(.MISMATCH(1)) d1 (
        .clk(clk), .reset(reset), .en(en), .in(in_s),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .state(st[1]), .step(sp[1]), .advance(adv[1]), .mismatch(mm[1]),
        .wrap(wr[1]), .wrap_count(wc1), .out_signal(os[1]));

    gray_seq_tracker #(.WRAP_W(2)) d2 (
        .clk(clk), .reset(reset), .en(en), .in(in_s),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .state(st[2]), .step(sp[2]), .advance(adv[2]), .mismatch(mm[2]),
        .wrap(wr[2]), .wrap_count(wc2), .out_signal(os[2]));

    gray_seq_tracker #(.ENC(1)) d3 (
        .clk(clk), .reset(reset), .en(en), .in(in_s),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .state(st[3]), .step(sp[3]), .advance(adv[3]), .mismatch(mm[3]),
        .wrap(wr[3]), .wrap_count(wc3), .out_signal(os[3]));

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset   = 1'b1;
        en      = 1'b0;
        load_en = 1'b0;
        in_s    = 2'd0;
        tick;
        reset = 1'b0;
    endtask

    // n matching symbols starting at table index s0 (default table)
    task automatic run_seq(input int s0, input int n);
        en = 1'b1;
        for (int k = 0; k < n; k++) begin
            in_s = 2'((s0 + k) % 4);
            tick;
        end
    endtask

    function automatic logic [4:0] gray(input int s);
        logic [4:0] b;
        b = 5'(s);
        return b ^ (b >> 1);
    endfunction

    initial begin
        logic [4:0] g;
        int e;
        load_addr = '0;
        load_data = '0;

        do_reset;
        check("rst_step", sp[0], 0);
        check("rst_state", st[0], 0);
        check("rst_adv", adv[0], 0);
        check("rst_mm", mm[0], 0);
        check("rst_wrap", wr[0], 0);
        check("rst_wc", wc0, 0);

        // full sequence
        en = 1'b1;
        for (int k = 0; k < 32; k++) begin
            in_s = 2'(k % 4);
            tick;
            e = (k + 1) % 32;
            g = gray(e);
            check("t1_step", sp[0], e);
            check("t1_gray", st[0], g);
            check("t1_enc1", st[3], e);
            check("t1_out", os[0], ^g[2:0]);
            check("t1_adv", adv[0], 1);
            check("t1_wrap", wr[0], (k == 31) ? 1 : 0);
        end
        check("t1_wc", wc0, 1);
        check("t1_wc2", wc2, 1);

        // hold on mismatch at step 5
        run_seq(0, 5);
        check("t2_at5", sp[0], 5);
        in_s = 2'd0;
        for (int k = 0; k < 3; k++) begin
            tick;
            check("t2_hold", sp[0], 5);
            check("t2_mm", mm[0], 1);
            check("t2_noadv", adv[0], 0);
            if (k == 0) begin
                check("t2_m1_step", sp[1], 0);
                check("t2_m1_mm", mm[1], 1);
            end
        end
        in_s = 2'd1;
        tick;
        check("t2_step6", sp[0], 6);
        check("t2_adv", adv[0], 1);
        check("t2_mmclr", mm[0], 0);

        // restart on mismatch
        do_reset;
        run_seq(0, 9);
        check("t3_at9", sp[1], 9);
        in_s = 2'd0;
        tick;
        check("t3_step", sp[1], 0);
        check("t3_mm", mm[1], 1);
        check("t3_wrap", wr[1], 0);
        in_s = 2'd1;
        tick;
        check("t3_s0_step", sp[1], 0);
        check("t3_s0_mm", mm[1], 1);

        // table write uses old entry this cycle
        do_reset;
        en        = 1'b1;
        load_en   = 1'b1;
        load_addr = 5'd0;
        load_data = 2'd3;
        in_s      = 2'd0;
        tick;
        load_en = 1'b0;
        check("t4_old", sp[0], 1);
        check("t4_adv", adv[0], 1);
        run_seq(1, 31);
        check("t4_wrap", wr[0], 1);
        check("t4_at0", sp[0], 0);
        in_s = 2'd0;
        tick;
        check("t4_mm", mm[0], 1);
        check("t4_hold", sp[0], 0);
        in_s = 2'd3;
        tick;
        check("t4_new", sp[0], 1);

        // saturating wrap counter
        do_reset;
        for (int s = 0; s < 5; s++) begin
            run_seq(0, 32);
            check("t5_wc2", wc2, (s < 2) ? s + 1 : 3);
        end
        check("t5_wc8", wc0, 5);
        en = 1'b0;
        tick;
        check("t5_en0_wc", wc2, 3);
        check("t5_en0_step", sp[2], 0);
        check("t5_en0_adv", adv[2], 0);
        check("t5_en0_wrap", wr[2], 0);

        // reset beats load mid-sequence
        do_reset;
        run_seq(0, 17);
        check("t6_at17", sp[0], 17);
        reset     = 1'b1;
        en        = 1'b1;
        load_en   = 1'b1;
        load_addr = 5'd0;
        load_data = 2'd2;
        in_s      = 2'd1;
        tick;
        check("t6_step", sp[0], 0);
        check("t6_adv", adv[0], 0);
        check("t6_mm", mm[0], 0);
        check("t6_wc", wc0, 0);
        reset   = 1'b0;
        load_en = 1'b0;
        in_s    = 2'd0;
        tick;
        check("t6_tbl", sp[0], 1);
        check("t6_enc1", st[3], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
